// File: rtl/rst_sequencer_if.sv
// Reset-sequencer bus: PLL lock and software request in, per-domain resets and ready out.
interface rst_sequencer_if #(
    parameter int unsigned NUM_DOMAINS = 3
);
    logic                   locked;
    logic                   sw_rst_req;
    logic [NUM_DOMAINS-1:0] rst_dom;
    logic                   ready;

    modport master (
        output locked,
        output sw_rst_req,
        input  rst_dom,
        input  ready
    );

    modport slave (
        input  locked,
        input  sw_rst_req,
        output rst_dom,
        output ready
    );
endinterface

// File: rtl/rst_sequencer.sv
// Lock-driven reset sequencer: releases per-domain resets in index order with
// programmable spacing once the synchronized PLL lock has been stable long enough.
module rst_sequencer #(
    parameter int unsigned NUM_DOMAINS   = 3,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned GAP_CYCLES    = 8
) (
    input logic            pclk,
    input logic            rst,
    rst_sequencer_if.slave bus
);
    localparam int unsigned MAX_CYCLES = (STABLE_CYCLES > GAP_CYCLES) ? STABLE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned IDX_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STABLE  = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    logic                   sync_q1;
    logic                   locked_s;
    logic                   abort;
    state_t                 state;
    logic [CNT_W-1:0]       counter;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [IDX_W-1:0]       idx;
    logic [NUM_DOMAINS-1:0] rst_dom;
    logic                   ready;

    // Two-flop synchronizer for the asynchronous PLL lock flag
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            sync_q1  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q1  <= bus.locked;
            locked_s <= sync_q1;
        end
    end

    assign abort   = !locked_s || bus.sw_rst_req;
    // counter holds edges already counted; cnt_nxt includes the current edge
    assign cnt_nxt = counter + CNT_W'(1);

    // Sequencing FSM; releases shift a zero in from the bottom so order is structural
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state   <= HOLD;
            counter <= '0;
            idx     <= '0;
            rst_dom <= '1;
            ready   <= 1'b0;
        end else if (abort) begin
            state   <= HOLD;
            counter <= '0;
            idx     <= '0;
            rst_dom <= '1;
            ready   <= 1'b0;
        end else begin
            case (state)
                HOLD, STABLE: begin
                    if (cnt_nxt == STABLE_LAST) begin
                        rst_dom <= rst_dom << 1;
                        counter <= '0;
                        if (NUM_DOMAINS == 1) begin
                            ready <= 1'b1;
                            state <= RUN;
                        end else begin
                            idx   <= IDX_W'(1);
                            state <= RELEASE;
                        end
                    end else begin
                        counter <= cnt_nxt;
                        state   <= STABLE;
                    end
                end
                RELEASE: begin
                    if (cnt_nxt == GAP_LAST) begin
                        rst_dom <= rst_dom << 1;
                        counter <= '0;
                        if (idx == IDX_LAST) begin
                            ready <= 1'b1;
                            state <= RUN;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        counter <= cnt_nxt;
                    end
                end
                RUN: begin
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

    assign bus.rst_dom = rst_dom;
    assign bus.ready   = ready;
endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: default, minimal-corner and 8-domain instances.
module tb_rst_sequencer;
    typedef struct {
        int         cyc;
        logic [7:0] dom;
        logic       rdy;
    } ev_t;

    logic pclk = 1'b0;
    logic rst  = 1'b0;
    int   cyc  = 0;
    int   total = 0;
    int   bad   = 0;

    ev_t qa[$];
    ev_t qb[$];
    ev_t qc[$];

    rst_sequencer_if #(.NUM_DOMAINS(3)) bus_a ();
    rst_sequencer_if #(.NUM_DOMAINS(1)) bus_b ();
    rst_sequencer_if #(.NUM_DOMAINS(8)) bus_c ();

    rst_sequencer #(.NUM_DOMAINS(3), .STABLE_CYCLES(16), .GAP_CYCLES(8)) dut_a (
        .pclk(pclk), .rst(rst), .bus(bus_a)
    );
    rst_sequencer #(.NUM_DOMAINS(1), .STABLE_CYCLES(1), .GAP_CYCLES(1)) dut_b (
        .pclk(pclk), .rst(rst), .bus(bus_b)
    );
    rst_sequencer #(.NUM_DOMAINS(8), .STABLE_CYCLES(4), .GAP_CYCLES(3)) dut_c (
        .pclk(pclk), .rst(rst), .bus(bus_c)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input logic [7:0] d, input logic r);
        ev_t e;
        e.cyc = c;
        e.dom = d;
        e.rdy = r;
        return e;
    endfunction

    // cyc < 0 means the edge number is not checked (initial reset)
    function automatic void check_ev(input string nm, input ev_t e, input int c,
                                     input logic [7:0] d, input logic r);
        total++;
        if ((e.cyc >= 0 && e.cyc != c) || d !== e.dom || r !== e.rdy) begin
            bad++;
            $display("FAIL %s: got cyc=%0d rst_dom=%h ready=%b, want cyc=%0d rst_dom=%h ready=%b",
                     nm, c, d, r, e.cyc, e.dom, e.rdy);
        end
    endfunction

    function automatic void unexpected(input string nm, input int c, input logic [8:0] v);
        total++;
        bad++;
        $display("FAIL %s: unexpected output change at cyc=%0d rst_dom=%h ready=%b, want no change",
                 nm, c, v[7:0], v[8]);
    endfunction

    // Ordering (zeros only from the bottom up) and ready == all released
    function automatic void inv_check(input string nm, input logic [7:0] d, input int n, input logic r);
        logic [8:0] m;
        logic [8:0] nd;
        logic       ok;
        m  = (9'd1 << n) - 9'd1;
        nd = ~{1'b0, d} & m;
        ok = ((nd & (nd + 9'd1)) == 9'd0) && (r == (d == 8'd0));
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got rst_dom=%h ready=%b at cyc=%0d, want ordered release and ready==(rst_dom==0)",
                     nm, d, r, cyc);
        end
    endfunction

    logic [8:0] last_a, last_b, last_c, cur_a, cur_b, cur_c;
    bit seen_a = 1'b0;
    bit seen_b = 1'b0;
    bit seen_c = 1'b0;

    // Monitors: every output change must match the next queued expectation
    always @(negedge pclk) begin
        cur_a = {bus_a.ready, 8'(bus_a.rst_dom)};
        inv_check("inv_a", 8'(bus_a.rst_dom), 3, bus_a.ready);
        if (!seen_a || cur_a != last_a) begin
            if (qa.size() == 0) unexpected("ev_a", cyc, cur_a);
            else check_ev("ev_a", qa.pop_front(), cyc, cur_a[7:0], cur_a[8]);
            seen_a = 1'b1;
            last_a = cur_a;
        end
    end

    always @(negedge pclk) begin
        cur_b = {bus_b.ready, 8'(bus_b.rst_dom)};
        if (!seen_b || cur_b != last_b) begin
            if (qb.size() == 0) unexpected("ev_b", cyc, cur_b);
            else check_ev("ev_b", qb.pop_front(), cyc, cur_b[7:0], cur_b[8]);
            seen_b = 1'b1;
            last_b = cur_b;
        end
    end

    always @(negedge pclk) begin
        cur_c = {bus_c.ready, 8'(bus_c.rst_dom)};
        inv_check("inv_c", 8'(bus_c.rst_dom), 8, bus_c.ready);
        if (!seen_c || cur_c != last_c) begin
            if (qc.size() == 0) unexpected("ev_c", cyc, cur_c);
            else check_ev("ev_c", qc.pop_front(), cyc, cur_c[7:0], cur_c[8]);
            seen_c = 1'b1;
            last_c = cur_c;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #2;
    endtask

    // Default instance: dom0/dom1/dom2+ready spaced by 8 edges from dom0 edge d0
    task automatic seq_a(input int d0);
        qa.push_back(mk(d0,      8'h06, 1'b0));
        qa.push_back(mk(d0 + 8,  8'h04, 1'b0));
        qa.push_back(mk(d0 + 16, 8'h00, 1'b1));
    endtask

    int b;
    logic [7:0] v;

    initial begin
        bus_a.locked = 1'b0; bus_a.sw_rst_req = 1'b0;
        bus_b.locked = 1'b0; bus_b.sw_rst_req = 1'b0;
        bus_c.locked = 1'b0; bus_c.sw_rst_req = 1'b0;
        qa.push_back(mk(-1, 8'h07, 1'b0));
        qb.push_back(mk(-1, 8'h01, 1'b0));
        qc.push_back(mk(-1, 8'hFF, 1'b0));
        #1 rst = 1'b1;
        tick(3);

        // Nominal: locked before edge 1 -> 18/26/34
        rst = 1'b0;
        bus_a.locked = 1'b1;
        seq_a(cyc + 18);
        tick(40);

        // Lock loss in RUN, then relock
        bus_a.locked = 1'b0;
        qa.push_back(mk(cyc + 3, 8'h07, 1'b0));
        tick(5);
        bus_a.locked = 1'b1;
        seq_a(cyc + 18);
        tick(40);

        // Software reset pulse in RUN, then again while releasing the last domain
        bus_a.sw_rst_req = 1'b1;
        qa.push_back(mk(cyc + 1, 8'h07, 1'b0));
        tick(5);
        bus_a.sw_rst_req = 1'b0;
        b = cyc;
        qa.push_back(mk(b + 16, 8'h06, 1'b0));
        qa.push_back(mk(b + 24, 8'h04, 1'b0));
        tick(27);
        bus_a.sw_rst_req = 1'b1;
        qa.push_back(mk(cyc + 1, 8'h07, 1'b0));
        tick(2);
        bus_a.sw_rst_req = 1'b0;
        seq_a(cyc + 16);
        tick(40);

        // Lock glitch during the stable count restarts it from zero
        bus_a.locked = 1'b0;
        qa.push_back(mk(cyc + 3, 8'h07, 1'b0));
        tick(6);
        bus_a.locked = 1'b1;
        tick(10);
        bus_a.locked = 1'b0;
        tick(2);
        bus_a.locked = 1'b1;
        seq_a(cyc + 18);
        tick(40);

        // Async reset mid-release (rst_dom = 110)
        bus_a.sw_rst_req = 1'b1;
        qa.push_back(mk(cyc + 1, 8'h07, 1'b0));
        tick(1);
        bus_a.sw_rst_req = 1'b0;
        qa.push_back(mk(cyc + 16, 8'h06, 1'b0));
        tick(18);
        rst = 1'b1;
        qa.push_back(mk(cyc, 8'h07, 1'b0));
        tick(2);
        rst = 1'b0;
        seq_a(cyc + 18);
        tick(40);

        // Single domain, minimal counts: release and ready together 3 edges after lock
        bus_b.locked = 1'b1;
        qb.push_back(mk(cyc + 3, 8'h00, 1'b1));
        tick(6);
        bus_b.locked = 1'b0;
        qb.push_back(mk(cyc + 3, 8'h01, 1'b0));
        tick(5);
        bus_b.locked = 1'b1;
        qb.push_back(mk(cyc + 3, 8'h00, 1'b1));
        tick(5);
        bus_b.sw_rst_req = 1'b1;
        qb.push_back(mk(cyc + 1, 8'h01, 1'b0));
        tick(3);
        bus_b.sw_rst_req = 1'b0;
        qb.push_back(mk(cyc + 1, 8'h00, 1'b1));
        tick(4);

        // Eight domains: full ordered release
        bus_c.locked = 1'b1;
        b = cyc;
        v = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            v = v << 1;
            qc.push_back(mk(b + 6 + 3 * i, v, (i == 7)));
        end
        tick(35);
        // Lock loss, relock, then lose lock part-way through the release
        bus_c.locked = 1'b0;
        qc.push_back(mk(cyc + 3, 8'hFF, 1'b0));
        tick(5);
        bus_c.locked = 1'b1;
        b = cyc;
        qc.push_back(mk(b + 6,  8'hFE, 1'b0));
        qc.push_back(mk(b + 9,  8'hFC, 1'b0));
        qc.push_back(mk(b + 12, 8'hF8, 1'b0));
        qc.push_back(mk(b + 15, 8'hF0, 1'b0));
        qc.push_back(mk(b + 16, 8'hFF, 1'b0));
        tick(13);
        bus_c.locked = 1'b0;
        tick(20);

        // Every queued expectation must have been consumed
        total++;
        if (qa.size() != 0) begin
            bad++;
            $display("FAIL pending_a: got %0d unmatched events, want 0", qa.size());
        end
        total++;
        if (qb.size() != 0) begin
            bad++;
            $display("FAIL pending_b: got %0d unmatched events, want 0", qb.size());
        end
        total++;
        if (qc.size() != 0) begin
            bad++;
            $display("FAIL pending_c: got %0d unmatched events, want 0", qc.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
